// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep controller: FSM states,
// waveform mode codes and default port widths.
package dds_pkg;

    localparam int FW_W_DEF    = 32;
    localparam int PW_W_DEF    = 12;
    localparam int DWELL_W_DEF = 16;
    localparam int STEP_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

    localparam logic [1:0] MODE_SINE   = 2'd0;
    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_SAW    = 2'd3;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Sweep configuration/request inputs and DDS-facing outputs of the sweep
// controller, bundled for connection between a host (master) and the block.
interface dds_sweep_ctrl_if
    import dds_pkg::*;
#(
    parameter int FW_W    = FW_W_DEF,
    parameter int PW_W    = PW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
);

    logic                  i_start;
    logic                  i_stop;
    logic [FW_W-1:0]       i_f_start;
    logic [FW_W-1:0]       i_f_stop;
    logic [FW_W-1:0]       i_f_step;
    logic [DWELL_W-1:0]    i_dwell;
    logic [PW_W-1:0]       i_pword;
    logic [1:0]            i_mode;
    logic                  i_continuous;

    logic [FW_W-1:0]       o_fword;
    logic                  o_fword_vld;
    logic [PW_W-1:0]       o_pword;
    logic                  o_pword_vld;
    logic [1:0]            o_mode;
    logic                  o_mode_vld;
    logic                  o_busy;
    logic                  o_done;
    logic [STEP_CNT_W-1:0] o_step_cnt;

    modport master (
        output i_start, i_stop, i_f_start, i_f_stop, i_f_step, i_dwell,
               i_pword, i_mode, i_continuous,
        input  o_fword, o_fword_vld, o_pword, o_pword_vld, o_mode, o_mode_vld,
               o_busy, o_done, o_step_cnt
    );

    modport slave (
        input  i_start, i_stop, i_f_start, i_f_stop, i_f_step, i_dwell,
               i_pword, i_mode, i_continuous,
        output o_fword, o_fword_vld, o_pword, o_pword_vld, o_mode, o_mode_vld,
               o_busy, o_done, o_step_cnt
    );

endinterface

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter timing the hold period of each tone; expire pulses
// in the last cycle of a period so the next word lands exactly D cycles later.
module dds_dwell_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    // Parks at zero after expiring, so an unreloaded period fires only once.
    assign expire = en && (cnt == W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller: steps the DDS frequency word from start to stop
// in fixed increments with a programmable dwell, and issues phase/mode at start.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW_W    = FW_W_DEF,
    parameter int PW_W    = PW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    dds_sweep_ctrl_if.slave  bus
);

    sweep_state_e          state;

    logic [FW_W-1:0]       sh_f_start;
    logic [FW_W-1:0]       sh_f_stop;
    logic [FW_W-1:0]       sh_f_step;
    logic [DWELL_W-1:0]    sh_dwell;
    logic [PW_W-1:0]       sh_pword;
    logic [1:0]            sh_mode;
    logic                  sh_cont;

    logic [FW_W-1:0]       fword_q;
    logic                  fword_vld_q;
    logic [PW_W-1:0]       pword_q;
    logic                  pword_vld_q;
    logic [1:0]            mode_q;
    logic                  mode_vld_q;
    logic                  done_q;
    logic [STEP_CNT_W-1:0] step_cnt_q;

    logic [FW_W:0]         sum;
    logic                  step_ok;
    logic                  evaluate;
    logic                  tmr_load;
    logic                  tmr_en;
    logic                  tmr_expire;

    // The extra sum bit catches a carry so the word never wraps modulo 2^FW_W.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sum      = {1'b0, fword_q} + {1'b0, sh_f_step};
        step_ok  = 1'b0;
        evaluate = 1'b0;
        if (!sum[FW_W] && (sum[FW_W-1:0] <= sh_f_stop)) begin
            step_ok = 1'b1;
        end
        // A zero step holds the start tone indefinitely instead of re-emitting it.
        if (state == ST_DWELL && tmr_expire && sh_f_step != '0) begin
            evaluate = 1'b1;
        end
    end

    assign tmr_en   = (state == ST_DWELL);
    assign tmr_load = (state == ST_LOAD) || (evaluate && (step_ok || sh_cont));

    dds_dwell_timer #(.W(DWELL_W)) u_dwell_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (sh_dwell),
        .expire   (tmr_expire)
    );

    // NOTE: shadow config has no reset; it is always written in IDLE before LOAD reads it.
    always_ff @(posedge i_clk) begin
        if (state == ST_IDLE && bus.i_start && !bus.i_stop) begin
            sh_f_start <= bus.i_f_start;
            sh_f_stop  <= bus.i_f_stop;
            sh_f_step  <= bus.i_f_step;
            sh_dwell   <= (bus.i_dwell == '0) ? DWELL_W'(1) : bus.i_dwell;
            sh_pword   <= bus.i_pword;
            sh_mode    <= bus.i_mode;
            sh_cont    <= bus.i_continuous;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            fword_q     <= '0;
            fword_vld_q <= 1'b0;
            pword_q     <= '0;
            pword_vld_q <= 1'b0;
            mode_q      <= '0;
            mode_vld_q  <= 1'b0;
            done_q      <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            // NOTE: strobes default low each cycle and are raised only where issued, making them single-cycle.
            fword_vld_q <= 1'b0;
            pword_vld_q <= 1'b0;
            mode_vld_q  <= 1'b0;
            done_q      <= 1'b0;
            if (bus.i_stop) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.i_start) begin
                            state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        fword_q     <= sh_f_start;
                        pword_q     <= sh_pword;
                        mode_q      <= sh_mode;
                        fword_vld_q <= 1'b1;
                        pword_vld_q <= 1'b1;
                        mode_vld_q  <= 1'b1;
                        step_cnt_q  <= '0;
                        state       <= ST_DWELL;
                    end
                    ST_DWELL: begin
                        if (evaluate) begin
                            if (step_ok) begin
                                fword_q     <= sum[FW_W-1:0];
                                fword_vld_q <= 1'b1;
                                if (step_cnt_q != '1) begin
                                    step_cnt_q <= step_cnt_q + STEP_CNT_W'(1);
                                end
                            end else if (sh_cont) begin
                                fword_q     <= sh_f_start;
                                fword_vld_q <= 1'b1;
                                step_cnt_q  <= '0;
                            end else begin
                                done_q <= 1'b1;
                                state  <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_fword     = fword_q;
    assign bus.o_fword_vld = fword_vld_q;
    assign bus.o_pword     = pword_q;
    assign bus.o_pword_vld = pword_vld_q;
    assign bus.o_mode      = mode_q;
    assign bus.o_mode_vld  = mode_vld_q;
    assign bus.o_busy      = (state != ST_IDLE);
    assign bus.o_done      = done_q;
    assign bus.o_step_cnt  = step_cnt_q;

endmodule
